apb_timer_slave: RTL and testbench
==================================

APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of reg_addr.
REQ-002 Parameter WAIT_CYCLES, default 1, legal range 0..3: number of wait states inserted in the access phase before reg_ready_1 is asserted.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset; synchronous and active-high.
REQ-005 Port reg_psel, input, 1: APB select.
REQ-006 Port reg_enable, input, 1: APB enable; high marks the access phase.
REQ-007 Port reg_rw, input, 1: transfer direction; 1 = write, 0 = read.
REQ-008 Port reg_addr, input, ADDR_WIDTH: byte address; only bits [4:2] are decoded.
REQ-009 Port reg_datai, input, 32: write data from the bridge.
REQ-010 Port reg_datao, output, 32: read data to the bridge.
REQ-011 Port reg_ready_1, output, 1: transfer completion to the bridge.
REQ-012 Port irq, output, 1: level interrupt.

Function
REQ-013 Register map (word offsets):
- 0x00 CTRL: [0] EN, [1] RELOAD, [2] IE; other bits read 0.
- 0x04 LOAD: 32 bits.
- 0x08 COUNT: 32 bits, read-only.
- 0x0C STATUS: [0] EXP, write-1-to-clear.
- 0x10 PSC: [15:0].
- Unmapped offsets 0x14..0x1C: reads return 0; writes are ignored.
REQ-014 Wait states: a wait counter clears while ~(reg_psel & reg_enable) and increments while reg_psel & reg_enable & ~reg_ready_1.
REQ-015 reg_ready_1 = reg_psel & reg_enable & (wait counter == WAIT_CYCLES); with WAIT_CYCLES=0 it is asserted in the first access-phase cycle.
REQ-016 Read data: reg_datao is combinational from the decoded address and SHALL be valid whenever reg_ready_1 is high.
REQ-017 Read address alignment: reg_addr[1:0] is ignored on reads, so the full aligned word is returned.
REQ-018 Write commit: a write takes effect only in the cycle where reg_psel & reg_enable & reg_rw & reg_ready_1 are all high, and exactly once per transfer.
REQ-019 Partial writes: writes with reg_addr[1:0] != 0 are completed (ready asserted) but change no state; only full-word writes are supported.
REQ-020 Tick generation: while EN=1, the prescaler counts 0..PSC and emits a one-cycle tick when it equals PSC, then restarts at 0.
- PSC=0 gives a tick every cycle.
- While EN=0 the prescaler holds at 0.
REQ-021 Count decrement: on a tick with COUNT != 0, COUNT decrements by 1.
REQ-022 Expiry: on a tick with COUNT == 0, EXP is set.
- If RELOAD=1, COUNT <= LOAD.
- If RELOAD=0, EN <= 0 and COUNT holds at 0.
REQ-023 LOAD write: writing LOAD also writes COUNT with the same value in the same cycle, restarts the prescaler at 0, and suppresses any tick in that cycle.
REQ-024 CTRL write: a write that changes EN from 0 to 1 restarts the prescaler at 0.
REQ-025 Simultaneous CTRL write and expiry: a CTRL write overrides the hardware EN clear.
REQ-026 Simultaneous EXP clear and expiry: when a W1C on STATUS[0] coincides with an expiry, set wins and EXP stays 1.
REQ-027 irq = EXP & IE, driven from registers (no combinational path from APB inputs).
REQ-028 Mid-transfer abort: if reg_psel drops before ready, the transfer is abandoned and the wait counter clears, with no register change.

Reset
REQ-029 Reset SHALL clear CTRL, LOAD, COUNT, EXP, PSC, the prescaler and the wait counter to 0.
REQ-030 During and after reset: reg_ready_1 = 0, irq = 0, and reg_datao = 0 unless a mapped access is in progress.
REQ-031 Reset asserted mid-transfer aborts the transfer with no register write; the next cycle behaves as idle.

Verification
REQ-032 WAIT_CYCLES=1: write 0x0000_000A to 0x04, then read 0x08 -> ready asserted on the 2nd enable cycle of each transfer; read returns 0x0000_000A.
REQ-033 LOAD=3, PSC=0, CTRL=0x1 (one-shot) -> COUNT reads 3,2,1,0 on consecutive cycles; EXP=1 on the next cycle; EN then reads 0; COUNT stays 0.
REQ-034 LOAD=2, PSC=1, CTRL=0x7 -> a tick every 2 cycles; COUNT sequence 2,1,0,2; irq rises at the first expiry and stays high until 0x1 is written to 0x0C.
REQ-035 W1C to STATUS in the same cycle as an expiry -> EXP remains 1 and irq remains high.
REQ-036 Write 0xFF to 0x05 (reg_addr[1:0]=1) -> ready asserted, LOAD unchanged; read of 0x14 -> 0x0000_0000.
REQ-037 Assert rst while a write to 0x00 is in its wait state -> CTRL stays 0, reg_ready_1 = 0 and irq = 0 the cycle after.

Source files
------------

// File: rtl/apb_timer_if.sv
// APB-style register bus between the bridge and the timer slave.
// valid/ready: a transfer is valid while reg_psel & reg_enable; it completes in the cycle reg_ready_1 is high.
interface apb_timer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  reg_psel;
  logic                  reg_enable;
  logic                  reg_rw;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]           reg_datai;
  logic [31:0]           reg_datao;
  logic                  reg_ready_1;

  modport master (
    output reg_psel, reg_enable, reg_rw, reg_addr, reg_datai,
    input  reg_datao, reg_ready_1
  );

  modport slave (
    input  reg_psel, reg_enable, reg_rw, reg_addr, reg_datai,
    output reg_datao, reg_ready_1
  );
endinterface

// File: rtl/apb_timer_slave.sv
// Down-counting timer with prescaler, reload and level interrupt behind an APB slave port
// that inserts WAIT_CYCLES wait states per access.
module apb_timer_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  apb_timer_if.slave   bus,
  output logic         irq
);
  localparam logic [1:0] WAIT_LIM = 2'(WAIT_CYCLES);

  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]  wait_cnt;
  logic        access;
  logic        ready;
  logic        wr_commit;
  logic [2:0]  idx;
  logic        wr_ctrl, wr_load, wr_stat, wr_psc;
  logic        en, reload, ie;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic        exp_q;
  logic [15:0] psc_q;
  logic [15:0] pre_cnt;
  logic        tick;
  logic        expire;
  logic        pre_restart;
  logic [31:0] rdata;
  logic        unused_addr;

  assign addr        = bus.reg_addr;
  assign unused_addr = &{1'b0, addr[ADDR_WIDTH-1:5]};
  assign idx         = addr[4:2];

  // Ready is masked by rst so a transfer caught by reset never completes.
  assign access          = bus.reg_psel & bus.reg_enable;
  assign ready           = access & ~rst & (wait_cnt == WAIT_LIM);
  assign bus.reg_ready_1 = ready;

  always_ff @(posedge clk) begin
    if (rst || !access) begin
      wait_cnt <= 2'd0;
    end else if (!ready) begin
      wait_cnt <= wait_cnt + 2'd1;
    end
  end

  // Only full-word writes in the completing cycle touch state.
  assign wr_commit = ready & bus.reg_rw & (addr[1:0] == 2'b00);
  assign wr_ctrl   = wr_commit & (idx == 3'd0);
  assign wr_load   = wr_commit & (idx == 3'd1);
  assign wr_stat   = wr_commit & (idx == 3'd3);
  assign wr_psc    = wr_commit & (idx == 3'd4);

  // >= keeps the prescaler from running past a PSC value lowered mid-count.
  assign tick        = en & (pre_cnt >= psc_q) & ~wr_load;
  assign expire      = tick & (count_q == 32'd0);
  assign pre_restart = wr_load | (wr_ctrl & ~en & bus.reg_datai[0]) | ~en | (pre_cnt >= psc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= 16'd0;
    end else if (pre_restart) begin
      pre_cnt <= 16'd0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      reload  <= 1'b0;
      ie      <= 1'b0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      exp_q   <= 1'b0;
      psc_q   <= 16'd0;
    end else begin
      // A software CTRL write wins over the one-shot EN clear.
      if (wr_ctrl) begin
        {ie, reload, en} <= bus.reg_datai[2:0];
      end else if (expire && !reload) begin
        en <= 1'b0;
      end
      if (wr_load) begin
        load_q <= bus.reg_datai;
      end
      if (wr_psc) begin
        psc_q <= bus.reg_datai[15:0];
      end
      if (wr_load) begin
        count_q <= bus.reg_datai;
      end else if (tick) begin
        if (count_q != 32'd0) begin
          count_q <= count_q - 32'd1;
        end else if (reload) begin
          count_q <= load_q;
        end
      end
      // Hardware set beats a simultaneous write-1-to-clear.
      if (expire) begin
        exp_q <= 1'b1;
      end else if (wr_stat && bus.reg_datai[0]) begin
        exp_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      3'd0:    rdata = {29'd0, ie, reload, en};
      3'd1:    rdata = load_q;
      3'd2:    rdata = count_q;
      3'd3:    rdata = {31'd0, exp_q};
      3'd4:    rdata = {16'd0, psc_q};
      default: rdata = 32'd0;
    endcase
  end

  assign bus.reg_datao = (bus.reg_psel & ~bus.reg_rw) ? rdata : 32'd0;
  assign irq           = exp_q & ie & ~rst;
endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave with WAIT_CYCLES=1: register access, timer modes,
// set/clear collision, partial/unmapped accesses, abort and reset mid-transfer.
module tb_apb_timer_slave;
  logic clk;
  logic rst;
  logic irq;
  int   checks;
  int   errors;
  logic [31:0] rd;
  int   ec;

  apb_timer_if #(.ADDR_WIDTH(32)) bus ();

  apb_timer_slave #(.ADDR_WIDTH(32), .WAIT_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic bus_idle();
    bus.reg_psel   = 1'b0;
    bus.reg_enable = 1'b0;
    bus.reg_rw     = 1'b0;
  endtask

  // Hold a read setup phase so reg_datao shows a register every cycle without a transfer.
  task automatic peek(input logic [31:0] a);
    bus.reg_psel   = 1'b1;
    bus.reg_enable = 1'b0;
    bus.reg_rw     = 1'b0;
    bus.reg_addr   = a;
  endtask

  task automatic apb_xfer(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdat, output int en_cycles);
    @(posedge clk); #1;
    bus.reg_psel   = 1'b1;
    bus.reg_enable = 1'b0;
    bus.reg_rw     = rw;
    bus.reg_addr   = a;
    bus.reg_datai  = d;
    @(posedge clk); #1;
    bus.reg_enable = 1'b1;
    en_cycles = 1;
    rdat = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.reg_ready_1) begin
        rdat = bus.reg_datao;
        break;
      end
      if (en_cycles >= 8) begin
        checks++; errors++;
        $display("FAIL apb_timeout addr=%h ready=0 after %0d enable cycles, required ready", a, en_cycles);
        break;
      end
      @(posedge clk); #1;
      en_cycles++;
    end
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int en_cycles);
    logic [31:0] dummy;
    apb_xfer(1'b1, a, d, dummy, en_cycles);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] rdat, output int en_cycles);
    apb_xfer(1'b0, a, 32'd0, rdat, en_cycles);
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    rst = 1'b1;
    bus_idle();
    bus.reg_addr  = 32'd0;
    bus.reg_datai = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.reg_ready_1, irq} !== 2'b00 || bus.reg_datao !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b irq=%b datao=%h, required 0 0 00000000", bus.reg_ready_1, irq, bus.reg_datao);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.reg_ready_1, irq} !== 2'b00 || bus.reg_datao !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_outputs ready=%b irq=%b datao=%h, required 0 0 00000000", bus.reg_ready_1, irq, bus.reg_datao);
    end
    for (int i = 0; i < 5; i++) begin
      apb_read(addrs[i], rd, ec);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg addr=%h got %h, required 00000000", addrs[i], rd);
      end
    end
  endtask

  task automatic test_basic_rw();
    apb_write(32'h04, 32'h0000_000A, ec);
    checks++;
    if (ec !== 2) begin errors++; $display("FAIL write_wait enable cycles %0d, required 2", ec); end
    apb_read(32'h08, rd, ec);
    checks++;
    if (ec !== 2) begin errors++; $display("FAIL read_wait enable cycles %0d, required 2", ec); end
    checks++;
    if (rd !== 32'h0000_000A) begin errors++; $display("FAIL count_after_load got %h, required 0000000a", rd); end
    apb_read(32'h06, rd, ec);
    checks++;
    if (rd !== 32'h0000_000A) begin errors++; $display("FAIL unaligned_read got %h, required 0000000a", rd); end
    apb_write(32'h10, 32'h0001_2345, ec);
    apb_read(32'h10, rd, ec);
    checks++;
    if (rd !== 32'h0000_2345) begin errors++; $display("FAIL psc_width got %h, required 00002345", rd); end
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_cnt [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
    apb_write(32'h10, 32'd0, ec);
    apb_write(32'h04, 32'd3, ec);
    apb_write(32'h00, 32'h1, ec);
    peek(32'h08);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.reg_datao !== exp_cnt[i]) begin
        errors++;
        $display("FAIL oneshot_count step %0d got %h, required %h", i, bus.reg_datao, exp_cnt[i]);
      end
    end
    peek(32'h0C);
    @(negedge clk);
    checks++;
    if (bus.reg_datao !== 32'd1) begin errors++; $display("FAIL oneshot_exp got %h, required 00000001", bus.reg_datao); end
    peek(32'h00);
    @(negedge clk);
    checks++;
    if (bus.reg_datao !== 32'd0) begin errors++; $display("FAIL oneshot_en_clear ctrl %h, required 00000000", bus.reg_datao); end
    peek(32'h08);
    @(negedge clk);
    checks++;
    if (bus.reg_datao !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_hold count %h irq %b, required 00000000 0", bus.reg_datao, irq);
    end
    bus_idle();
    apb_write(32'h0C, 32'h1, ec);
  endtask

  task automatic test_periodic();
    logic [31:0] exp_cnt [8] = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2, 32'd2};
    logic        exp_irq [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apb_write(32'h10, 32'd1, ec);
    apb_write(32'h04, 32'd2, ec);
    apb_write(32'h00, 32'h7, ec);
    peek(32'h08);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.reg_datao !== exp_cnt[i] || irq !== exp_irq[i]) begin
        errors++;
        $display("FAIL periodic step %0d count %h irq %b, required %h %b", i, bus.reg_datao, irq, exp_cnt[i], exp_irq[i]);
      end
    end
    bus_idle();
    apb_write(32'h00, 32'h6, ec);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky got %b, required 1", irq); end
    apb_write(32'h0C, 32'h1, ec);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b, required 0", irq); end
  endtask

  task automatic test_w1c_collision();
    apb_write(32'h10, 32'd0, ec);
    apb_write(32'h04, 32'd3, ec);
    apb_write(32'h00, 32'h5, ec);
    // Count 3 -> 0 over three ticks; expiry lands on the commit edge of the next write.
    apb_write(32'h0C, 32'h1, ec);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b, required 1", irq); end
    apb_read(32'h0C, rd, ec);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL set_wins_status got %h, required 00000001", rd); end
    apb_read(32'h00, rd, ec);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL collision_ctrl got %h, required 00000004", rd); end
    apb_write(32'h0C, 32'h1, ec);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL plain_w1c irq got %b, required 0", irq); end
  endtask

  task automatic test_partial_unmapped();
    apb_write(32'h05, 32'hFF, ec);
    checks++;
    if (ec !== 2) begin errors++; $display("FAIL partial_ready enable cycles %0d, required 2", ec); end
    apb_read(32'h04, rd, ec);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL partial_no_write load %h, required 00000003", rd); end
    apb_read(32'h14, rd, ec);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h, required 00000000", rd); end
    apb_write(32'h18, 32'hFFFF_FFFF, ec);
    apb_read(32'h18, rd, ec);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_write got %h, required 00000000", rd); end
    apb_write(32'h00, 32'hFFFF_FFFC, ec);
    apb_read(32'h00, rd, ec);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL ctrl_reserved got %h, required 00000004", rd); end
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    bus.reg_psel  = 1'b1;
    bus.reg_rw    = 1'b1;
    bus.reg_addr  = 32'h04;
    bus.reg_datai = 32'h55;
    @(posedge clk); #1;
    bus.reg_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.reg_ready_1 !== 1'b0) begin errors++; $display("FAIL abort_wait ready %b, required 0", bus.reg_ready_1); end
    @(posedge clk); #1;
    bus_idle();
    apb_read(32'h04, rd, ec);
    checks++;
    if (rd !== 32'd3 || ec !== 2) begin
      errors++;
      $display("FAIL abort_no_write load %h cycles %0d, required 00000003 2", rd, ec);
    end
  endtask

  task automatic test_reset_mid_xfer();
    apb_write(32'h04, 32'd0, ec);
    apb_write(32'h00, 32'h5, ec);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b, required 1", irq); end
    @(posedge clk); #1;
    bus.reg_psel  = 1'b1;
    bus.reg_rw    = 1'b1;
    bus.reg_addr  = 32'h00;
    bus.reg_datai = 32'h1;
    @(posedge clk); #1;
    bus.reg_enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.reg_ready_1 !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ready %b irq %b, required 0 0", bus.reg_ready_1, irq);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    apb_read(32'h00, rd, ec);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_mid_ctrl got %h, required 00000000", rd); end
    apb_read(32'h0C, rd, ec);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_status got %h irq %b, required 00000000 0", rd, irq);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_rw();
    test_oneshot();
    test_periodic();
    test_w1c_collision();
    test_partial_unmapped();
    test_abort();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
